// File: rtl/cola_pkg.sv
// Shared definitions for the cola vending datapath: state encoding, coin
// values and coin_type encodings, plus the default change-amount width.
package cola_pkg;

  // Change amounts are counted in half-yuan units; width shared with the controller.
  localparam int DEF_AMT_W = 5;

  // Payout FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_GAP   = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  // Coin values in half-yuan units.
  localparam logic [1:0] COIN_HALF = 2'd1;
  localparam logic [1:0] COIN_ONE  = 2'd2;

  // coin_type wire encodings.
  localparam logic COIN_TYPE_HALF = 1'b0;
  localparam logic COIN_TYPE_ONE  = 1'b1;

  // Value (half-yuan units) of the coin selected by a coin_type encoding.
  function automatic logic [1:0] coin_value(input logic coin_type);
    if (coin_type == COIN_TYPE_ONE) begin
      return COIN_ONE;
    end else begin
      return COIN_HALF;
    end
  endfunction

endpackage

// File: rtl/cola_ack_timer.sv
// Hopper acknowledge watchdog: clearable, enabled up-counter that stops at
// its terminal count ACK_TIMEOUT-1 and flags it.
module cola_ack_timer #(
  parameter int ACK_TIMEOUT = 64,
  parameter int TMR_W       = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST_CNT = TMR_W'(ACK_TIMEOUT - 1);

  logic [TMR_W-1:0] count_r;

  assign expired = (count_r == LAST_CNT);

  // Count wait cycles; clear wins over enable, and the count parks at terminal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {TMR_W{1'b0}};
    end else if (clr) begin
      count_r <= {TMR_W{1'b0}};
    end else if (en && !expired) begin
      count_r <= count_r + TMR_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/cola_change_dispenser.sv
// Change dispenser: accepts a change amount in half-yuan units and pays it
// out greedily (1-yuan coins first, then at most one 0.5-yuan coin) through
// a one-coin-per-request hopper handshake, with an ack watchdog that parks
// the block in a sticky fault state.
module cola_change_dispenser
  import cola_pkg::*;
#(
  parameter int AMT_W       = DEF_AMT_W,
  parameter int ACK_TIMEOUT = 64,
  parameter int TMR_W       = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chg_valid,
  input  logic [AMT_W-1:0] chg_amt,
  output logic             chg_ready,
  output logic             coin_req,
  output logic             coin_type,
  input  logic             coin_ack,
  output logic             done,
  output logic             fault,
  input  logic             fault_clr,
  output logic             busy,
  output logic [AMT_W-1:0] remaining
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [AMT_W-1:0] remaining_r;
  logic [AMT_W-1:0] remaining_nxt_s;
  logic [AMT_W-1:0] paid_rem_s;
  logic             coin_sel_s;
  logic             tmr_clr_s;
  logic             tmr_en_s;
  logic             tmr_expired_s;

  // A 1-yuan coin is only chosen when at least two half-units remain, so the
  // subtraction below can never underflow.
  assign coin_sel_s = (remaining_r >= AMT_W'(2)) ? COIN_TYPE_ONE : COIN_TYPE_HALF;
  assign paid_rem_s = remaining_r - AMT_W'(coin_value(coin_sel_s));

  // Watchdog runs only while a request is outstanding; an ack restarts it.
  assign tmr_en_s  = (state_r == ST_REQ);
  assign tmr_clr_s = (state_r != ST_REQ) || coin_ack;

  cola_ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .TMR_W       (TMR_W)
  ) u_ack_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr_s),
    .en      (tmr_en_s),
    .expired (tmr_expired_s)
  );

  // State and remaining-amount registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      remaining_r <= {AMT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      remaining_r <= remaining_nxt_s;
    end
  end

  // Next-state and next-remaining decode; ack takes priority over expiry.
  always_comb begin
    state_nxt_s     = state_r;
    remaining_nxt_s = remaining_r;
    case (state_r)
      ST_IDLE: begin
        if (chg_valid) begin
          remaining_nxt_s = chg_amt;
          if (chg_amt == {AMT_W{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (coin_ack) begin
          remaining_nxt_s = paid_rem_s;
          if (paid_rem_s == {AMT_W{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_GAP;
          end
        end else if (tmr_expired_s) begin
          state_nxt_s = ST_FAULT;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_GAP: begin
        state_nxt_s = ST_REQ;
      end
      ST_DONE: begin
        state_nxt_s     = ST_IDLE;
        remaining_nxt_s = {AMT_W{1'b0}};
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_nxt_s     = ST_IDLE;
          remaining_nxt_s = {AMT_W{1'b0}};
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        remaining_nxt_s = {AMT_W{1'b0}};
      end
    endcase
  end

  // Outputs decode registered state only.
  assign chg_ready = (state_r == ST_IDLE);
  assign coin_req  = (state_r == ST_REQ);
  assign coin_type = (state_r == ST_REQ) ? coin_sel_s : COIN_TYPE_HALF;
  assign done      = (state_r == ST_DONE);
  assign fault     = (state_r == ST_FAULT);
  assign busy      = (state_r == ST_REQ) || (state_r == ST_GAP) || (state_r == ST_DONE);
  assign remaining = remaining_r;

endmodule
